// File: rtl/training_lock_detector.sv
// training_lock_detector
//   Arms on `start`, timestamps edges of the serial training preamble and
//   averages 2**AVG_LOG2 half-bit intervals into a programmable baud divider.
//   Every interval is checked against the first one within +/-TOL samples.
//
// Ports
//   clk, rst_n        single clock, asynchronous active-low reset
//   start             arm request, honoured only while idle
//   enable            sample strobe; edges and interval counts use it
//   training          serial preamble line (idles high)
//   busy              high while armed or measuring
//   done / error      one-cycle result pulses
//   err_code          0 none, 1 tolerance, 2 overflow, 3 timeout (sticky)
//   locked            high after a successful lock
//   clk_div           measured divider, updated only on success
//
// Optional feature: define TRAINING_TIMEOUT_EN to add an edge-silence
// timeout of TIMEOUT_CYCLES clk cycles while armed or measuring.
module training_lock_detector #(
  parameter int PREAMBLE_COUNT = 8,
  parameter int DIV_WIDTH      = 8,
  parameter int AVG_LOG2       = 3,
  parameter int TOL            = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 enable,
  input  logic                 training,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 locked,
  output logic [DIV_WIDTH-1:0] clk_div
);

  localparam int CW = DIV_WIDTH + 1;             // interval counter width
  localparam int SW = DIV_WIDTH + AVG_LOG2 + 1;  // accumulator width
  localparam int IW = AVG_LOG2 + 1;              // accepted-interval index
  localparam logic [CW-1:0] CNT_MAX  = CW'(1) << DIV_WIDTH;
  localparam logic [IW-1:0] IDX_LAST = IW'((1 << AVG_LOG2) - 1);

  // The preamble must carry at least as many intervals as are averaged.
  generate
    if ((1 << AVG_LOG2) > 2 * PREAMBLE_COUNT - 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("training_lock_detector: AVG_LOG2 too large for PREAMBLE_COUNT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, state_nx;

  logic          prev, edge_det, fall;
  logic [CW-1:0] cnt, len, ref_len, dev;
  logic [SW-1:0] sum, sum_nx;
  logic [IW-1:0] idx;
  logic          tol_bad, last, ovf, tmo;
  logic          ev_done, ev_err;
  logic [1:0]    ev_code;

  assign edge_det = enable & (training ^ prev);
  assign fall     = edge_det & ~training;
  assign len      = cnt + CW'(1);
  assign dev      = (len >= ref_len) ? len - ref_len : ref_len - len;
  // The first interval becomes the reference, so it is never rejected.
  assign tol_bad  = (idx != '0) && (dev > CW'(TOL));
  assign sum_nx   = sum + SW'(len);
  assign last     = (idx == IDX_LAST);
  // An edge landing on the overflow cycle still closes a valid interval.
  assign ovf      = (cnt == CNT_MAX) && !edge_det;
  assign busy     = (state != IDLE);

`ifdef TRAINING_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] silence;

  // Counts raw clk cycles; saturates so it cannot wrap while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   silence <= '0;
    else if (edge_det || (state == IDLE && start)) silence <= '0;
    else if (silence != TW'(TIMEOUT_CYCLES))      silence <= silence + TW'(1);
  end
  assign tmo = busy && (silence == TW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ev_done  = 1'b0;
    ev_err   = 1'b0;
    ev_code  = 2'd0;
    unique case (state)
      IDLE: if (start) state_nx = ARM;
      ARM: begin
        if (fall) state_nx = MEASURE;
        else if (tmo) begin
          ev_err = 1'b1; ev_code = 2'd3; state_nx = IDLE;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          if (tol_bad) begin
            ev_err = 1'b1; ev_code = 2'd1; state_nx = IDLE;
          end else if (last) begin
            ev_done = 1'b1; state_nx = IDLE;
          end
        end else if (ovf) begin
          ev_err = 1'b1; ev_code = 2'd2; state_nx = IDLE;
        end else if (tmo) begin
          ev_err = 1'b1; ev_code = 2'd3; state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'd0;
      locked   <= 1'b0;
      clk_div  <= '0;
      cnt      <= '0;
      sum      <= '0;
      idx      <= '0;
      ref_len  <= '0;
    end else begin
      if (enable) prev <= training;
      done  <= ev_done;
      error <= ev_err;
      if (state == IDLE && start) begin
        locked   <= 1'b0;
        err_code <= 2'd0;
      end
      if (ev_done) begin
        locked  <= 1'b1;
        // Average of the accepted intervals, minus one: L = D+1 -> D.
        clk_div <= sum_nx[AVG_LOG2 +: DIV_WIDTH] - DIV_WIDTH'(1);
      end
      if (ev_err) begin
        locked   <= 1'b0;
        err_code <= ev_code;
      end
      if (state == ARM && fall) begin
        cnt <= '0;
        sum <= '0;
        idx <= '0;
      end else if (state == MEASURE) begin
        if (edge_det) begin
          cnt <= '0;
          if (idx == '0) ref_len <= len;
          if (!tol_bad) begin
            sum <= sum_nx;
            idx <= idx + IW'(1);
          end
        end else if (enable) begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_training_lock_detector.sv
// Self-checking bench for training_lock_detector (default build, no timeout).
// Each run is described by a list of interval lengths in enabled samples;
// the expected outcome and the sample on which it is decided are derived
// from those lengths directly.
module tb_training_lock_detector;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       training = 1'b1;
  logic       busy, done, error, locked;
  logic [1:0] err_code;
  logic [7:0] clk_div;

  int         n_tests = 0;
  int         n_fail = 0;
  int         exp_div = 0;

  always #5 clk = ~clk;

  training_lock_detector #(
    .PREAMBLE_COUNT(8), .DIV_WIDTH(8), .AVG_LOG2(3), .TOL(2), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable(enable), .training(training),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .locked(locked), .clk_div(clk_div)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 undecided, 1 done, 2 tolerance, 3 overflow
  task automatic run(input string nm, input int ivs[$], input int per, input bit low_start);
    int lv[$];
    int kind, ev_s, acc, sum, cd, e, d, lvl;
    if (low_start) lv = {0, 0, 1, 1};
    else           lv = {1, 1, 1};
    // reference model over the interval list
    kind = 0; ev_s = 1 << 30; acc = 0; sum = 0; cd = 0; e = lv.size();
    foreach (ivs[i]) begin
      if (kind == 0) begin
        d = ivs[i] - ivs[0];
        if (d < 0) d = -d;
        if (ivs[i] > 257) begin
          kind = 3; ev_s = e + 257;
        end else if (i > 0 && d > 2) begin
          kind = 2; ev_s = e + ivs[i];
        end else begin
          acc++; sum += ivs[i];
          if (acc == 8) begin
            kind = 1; ev_s = e + ivs[i]; cd = ((sum >> 3) - 1) & 255;
          end
        end
      end
      e += ivs[i];
    end
    // line waveform: one level per interval, closing edge, then stray edges
    lvl = 0;
    foreach (ivs[i]) begin
      for (int k = 0; k < ivs[i]; k++) lv.push_back(lvl);
      lvl ^= 1;
    end
    for (int k = 0; k < 3; k++) lv.push_back(lvl);
    for (int k = 0; k < 3; k++) lv.push_back(lvl ^ 1);
    for (int k = 0; k < 3; k++) lv.push_back(lvl);

    enable = 1'b1; training = lv[0][0];
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, " busy_after_start"}, busy, 1);
    chk({nm, " locked_cleared"}, locked, 0);
    chk({nm, " err_code_cleared"}, err_code, 0);
    foreach (lv[s]) begin
      for (int j = 0; j < per; j++) begin
        enable = (j == 0);
        training = lv[s][0];
        tick();
        chk({nm, " done"}, done, (kind == 1 && s == ev_s && j == 0));
        chk({nm, " error"}, error, (kind >= 2 && s == ev_s && j == 0));
        chk({nm, " busy"}, busy, (s < ev_s));
      end
    end
    enable = 1'b0;
    if (kind == 1) exp_div = cd;
    chk({nm, " locked"}, locked, (kind == 1));
    chk({nm, " err_code"}, err_code, (kind == 1) ? 0 : (kind == 2) ? 1 : 2);
    chk({nm, " clk_div"}, clk_div, exp_div);
  endtask

  task automatic run_reset_mid();
    enable = 1'b1; training = 1'b1;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    training = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    chk("rst busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst locked", locked, 0);
    chk("rst err_code", err_code, 0);
    chk("rst clk_div", clk_div, 0);
    tick();
    rst_n = 1'b1;
    exp_div = 0;
    for (int k = 0; k < 40; k++) begin
      training = ((k / 5) % 2 == 1);
      tick();
      chk("rst no_done", done, 0);
      chk("rst no_error", error, 0);
      chk("rst no_busy", busy, 0);
    end
  endtask

  initial begin
    int q[$];
    int base, spread, n, per, l;
    tick(); tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset locked", locked, 0);
    chk("reset err_code", err_code, 0);
    chk("reset clk_div", clk_div, 0);
    rst_n = 1'b1;
    tick();

    q = {};
    for (int i = 0; i < 15; i++) q.push_back(10);
    run("nominal", q, 1, 1'b0);
    q = {10, 11, 9, 10, 12, 10, 8, 10};
    run("jitter", q, 1, 1'b0);
    q = {10, 10, 10, 13, 10, 10};
    run("tolerance", q, 1, 1'b0);
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(10);
    run("strobed", q, 2, 1'b0);
    q = {600};
    run("overflow", q, 1, 1'b0);
    q = {257, 257, 257, 257, 257, 257, 257, 257};
    run("edge_at_max", q, 1, 1'b0);
    q = {};
    for (int i = 0; i < 9; i++) q.push_back(7);
    run("low_at_start", q, 1, 1'b1);
    q = {5, 6, 7, 5, 4, 6, 3, 5};
    run("tol_final", q, 1, 1'b0);

    for (int r = 0; r < 20; r++) begin
      base   = int'($urandom_range(3, 40));
      spread = ($urandom_range(0, 3) == 0) ? 4 : 2;
      n      = int'($urandom_range(8, 11));
      per    = int'($urandom_range(1, 3));
      q = {};
      for (int i = 0; i < n; i++) begin
        l = base + int'($urandom_range(0, 2 * spread)) - spread;
        q.push_back((l < 1) ? 1 : l);
      end
      run($sformatf("rand%0d", r), q, per, r[0]);
    end

    run_reset_mid();
    q = {};
    for (int i = 0; i < 8; i++) q.push_back(12);
    run("after_reset", q, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
